// File: rtl/reg_writeback.sv
// reg_writeback
//   Write-back stage for a 7-entry, 8-bit register file with a memory side
//   path. An offered write-back (wb_valid) is accepted on a rising edge when
//   wb_ready is high.
//   - cmdst 0-6 writes R0-R6 directly. Back-to-back writes are accepted
//     every cycle.
//   - cmdst 7 latches the data into mem_wdata and raises mem_wr_req until
//     mem_ack arrives. If no ack arrives within TIMEOUT cycles, the request
//     is abandoned and the sticky wb_err flag is set.
//
// Ports
//   clk         : single clock, rising edge
//   rst_n       : asynchronous active-low reset
//   cmdst[2:0]  : destination select (0-6 = R0-R6, 7 = memory)
//   wbdata[7:0] : write-back data
//   wb_valid    : write-back offered
//   wb_ready    : write-back can be accepted
//   R0..R6[7:0] : register-file contents
//   mem_wdata   : data held for the memory write
//   mem_wr_req  : memory write request (high for the whole MEMWR state)
//   mem_ack     : single-cycle memory write acknowledge
//   wb_err      : sticky timeout flag
//   err_clr     : synchronous clear for wb_err
module reg_writeback #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] cmdst,
  input  logic [7:0] wbdata,
  input  logic       wb_valid,
  output logic       wb_ready,
  output logic [7:0] R0,
  output logic [7:0] R1,
  output logic [7:0] R2,
  output logic [7:0] R3,
  output logic [7:0] R4,
  output logic [7:0] R5,
  output logic [7:0] R6,
  output logic [7:0] mem_wdata,
  output logic       mem_wr_req,
  input  logic       mem_ack,
  output logic       wb_err,
  input  logic       err_clr
);

  typedef enum logic {
    IDLE  = 1'b0,
    MEMWR = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [6:0][7:0] regs_q, regs_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  // Goes high on the first clock after reset release. This keeps wb_ready
  // low during reset and until the block has seen a clock.
  logic            alive_q, alive_d;

  logic accept;

  assign wb_ready   = alive_q && (state_q == IDLE);
  assign mem_wr_req = (state_q == MEMWR);
  assign accept     = wb_valid && wb_ready;

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    alive_d     = 1'b1;

    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmdst == 3'd7) begin
            mem_wdata_d = wbdata;
            cnt_d       = 8'd0;
            state_d     = MEMWR;
          end else begin
            for (int i = 0; i < 7; i++) begin
              if (cmdst == 3'(i)) begin
                regs_d[i] = wbdata;
              end
            end
          end
        end
      end
      MEMWR: begin
        // An ack on the final cycle takes priority over the timeout.
        if (mem_ack) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          // A new timeout overrides a simultaneous err_clr.
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      regs_q      <= '0;
      mem_wdata_q <= 8'h00;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      alive_q     <= alive_d;
    end
  end

  assign R0        = regs_q[0];
  assign R1        = regs_q[1];
  assign R2        = regs_q[2];
  assign R3        = regs_q[3];
  assign R4        = regs_q[4];
  assign R5        = regs_q[5];
  assign R6        = regs_q[6];
  assign mem_wdata = mem_wdata_q;
  assign wb_err    = err_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed testbench for reg_writeback (TIMEOUT = 15).
module tb_reg_writeback;

  logic       clk;
  logic       rst_n;
  logic [2:0] cmdst;
  logic [7:0] wbdata;
  logic       wb_valid;
  logic       wb_ready;
  logic [7:0] R0, R1, R2, R3, R4, R5, R6;
  logic [7:0] mem_wdata;
  logic       mem_wr_req;
  logic       mem_ack;
  logic       wb_err;
  logic       err_clr;

  logic [7:0] r [7];
  assign r[0] = R0;
  assign r[1] = R1;
  assign r[2] = R2;
  assign r[3] = R3;
  assign r[4] = R4;
  assign r[5] = R5;
  assign r[6] = R6;

  int tests;
  int fails;
  int n;

  reg_writeback #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmdst     (cmdst),
    .wbdata    (wbdata),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .R0        (R0),
    .R1        (R1),
    .R2        (R2),
    .R3        (R3),
    .R4        (R4),
    .R5        (R5),
    .R6        (R6),
    .mem_wdata (mem_wdata),
    .mem_wr_req(mem_wr_req),
    .mem_ack   (mem_ack),
    .wb_err    (wb_err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_mem(input logic [7:0] d);
    cmdst    = 3'd7;
    wbdata   = d;
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    cmdst    = 3'd0;
    wbdata   = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    cmdst    = 3'd0;
    wbdata   = 8'h00;
    wb_valid = 1'b0;
    mem_ack  = 1'b0;
    err_clr  = 1'b0;

    // Reset state
    #23;
    check("rst_ready", {7'd0, wb_ready}, 8'd0);
    check("rst_req", {7'd0, mem_wr_req}, 8'd0);
    check("rst_err", {7'd0, wb_err}, 8'd0);
    check("rst_mwdata", mem_wdata, 8'h00);
    for (int i = 0; i < 7; i++) check($sformatf("rst_R%0d", i), r[i], 8'h00);
    #5 rst_n = 1'b1;
    tick();
    check("ready_after_rel", {7'd0, wb_ready}, 8'd1);

    // Back-to-back register writes
    for (int i = 0; i < 7; i++) begin
      cmdst    = 3'(i);
      wbdata   = 8'h10 + 8'(i);
      wb_valid = 1'b1;
      check($sformatf("b2b_ready%0d", i), {7'd0, wb_ready}, 8'd1);
      tick();
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 7; i++) check($sformatf("b2b_R%0d", i), r[i], 8'h10 + 8'(i));
    $display("[TB] register path done");

    // Memory write acked on the 3rd MEMWR cycle
    accept_mem(8'hA5);
    check("mem_c1_req", {7'd0, mem_wr_req}, 8'd1);
    check("mem_c1_ready", {7'd0, wb_ready}, 8'd0);
    check("mem_c1_wdata", mem_wdata, 8'hA5);
    tick();
    check("mem_c2_req", {7'd0, mem_wr_req}, 8'd1);
    tick();
    check("mem_c3_req", {7'd0, mem_wr_req}, 8'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("mem_done_req", {7'd0, mem_wr_req}, 8'd0);
    check("mem_done_ready", {7'd0, wb_ready}, 8'd1);
    check("mem_done_wdata", mem_wdata, 8'hA5);
    check("mem_done_err", {7'd0, wb_err}, 8'd0);
    for (int i = 0; i < 7; i++) check($sformatf("mem_R%0d", i), r[i], 8'h10 + 8'(i));
    $display("[TB] memory path done");

    // Timeout: count request cycles
    accept_mem(8'hC3);
    n = 0;
    while (mem_wr_req && n < 40) begin
      n++;
      tick();
    end
    check("to_cycles", 8'(n), 8'd15);
    check("to_err", {7'd0, wb_err}, 8'd1);
    check("to_ready", {7'd0, wb_ready}, 8'd1);
    // Error does not block write-backs
    cmdst    = 3'd3;
    wbdata   = 8'h33;
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    check("err_nb_R3", R3, 8'h33);
    check("err_nb_err", {7'd0, wb_err}, 8'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", {7'd0, wb_err}, 8'd0);
    $display("[TB] timeout done, %0d request cycles", n);

    // Ack on the timeout cycle wins
    accept_mem(8'h11);
    repeat (14) tick();
    check("coll_c15_req", {7'd0, mem_wr_req}, 8'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("coll_req", {7'd0, mem_wr_req}, 8'd0);
    check("coll_err", {7'd0, wb_err}, 8'd0);
    $display("[TB] ack/timeout collision done");

    // Timeout set wins over a simultaneous err_clr
    accept_mem(8'h22);
    repeat (14) tick();
    check("setw_c15_req", {7'd0, mem_wr_req}, 8'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("setw_req", {7'd0, mem_wr_req}, 8'd0);
    check("setw_err", {7'd0, wb_err}, 8'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("setw_clr", {7'd0, wb_err}, 8'd0);
    $display("[TB] set-over-clear done");

    // Ack in IDLE is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_req", {7'd0, mem_wr_req}, 8'd0);
    check("idle_ack_ready", {7'd0, wb_ready}, 8'd1);
    $display("[TB] idle ack done");

    // Stall: offer an R2 write while MEMWR is busy
    accept_mem(8'h5A);
    wb_valid = 1'b1;
    cmdst    = 3'd2;
    wbdata   = 8'hFF;
    check("stall_ready", {7'd0, wb_ready}, 8'd0);
    tick();
    check("stall_R2_hold", R2, 8'h12);
    check("stall_wdata", mem_wdata, 8'h5A);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("stall_R2_idle", R2, 8'h12);
    check("stall_ready_back", {7'd0, wb_ready}, 8'd1);
    tick();
    wb_valid = 1'b0;
    check("stall_R2_new", R2, 8'hFF);
    check("stall_wdata_kept", mem_wdata, 8'h5A);
    $display("[TB] stall done");

    // Reset asserted in the 2nd MEMWR cycle
    accept_mem(8'h77);
    tick();
    check("rmid_req_before", {7'd0, mem_wr_req}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rmid_req", {7'd0, mem_wr_req}, 8'd0);
    check("rmid_err", {7'd0, wb_err}, 8'd0);
    check("rmid_ready", {7'd0, wb_ready}, 8'd0);
    check("rmid_wdata", mem_wdata, 8'h00);
    for (int i = 0; i < 7; i++) check($sformatf("rmid_R%0d", i), r[i], 8'h00);
    #3 rst_n = 1'b1;
    tick();
    check("rmid_ready_rel", {7'd0, wb_ready}, 8'd1);
    check("rmid_req_rel", {7'd0, mem_wr_req}, 8'd0);
    $display("[TB] reset mid-op done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
